// File: rtl/m_proc_mc.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/WB sequencing with sticky halt on illegal encodings.
// Latency 4 cycles per instruction plus one per fetch wait state; fetch stalls while w_ivalid=0.
module m_proc_mc #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          REG_CNT  = 32
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    output logic        w_ireq,
    output logic [31:0] w_iaddr,
    input  logic        w_ivalid,
    input  logic [31:0] w_idata,
    output logic        w_retire,
    output logic        w_rf_we,
    output logic [4:0]  w_rf_wa,
    output logic [31:0] w_rf_wd,
    output logic [31:0] w_pc,
    output logic        w_halt
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_OR, OP_AND, OP_LUI, OP_JAL, OP_BEQ, OP_BNE
    } alu_op_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_res;
    logic [31:0] r_tgt;
    alu_op_t     r_op;
    logic        r_use_imm;
    logic        r_wr;
    logic [31:0] r_rf [32];

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;

    assign w_opc = r_ir[6:0];
    assign w_f3  = r_ir[14:12];
    assign w_f7  = r_ir[31:25];
    assign w_rd  = r_ir[11:7];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];

    function automatic logic idx_bad(input logic [4:0] idx);
        return int'({27'b0, idx}) >= REG_CNT;
    endfunction

    alu_op_t     w_dec_op;
    logic [31:0] w_dec_imm;
    logic        w_dec_use_imm;
    logic        w_dec_wr;
    logic        w_dec_ok;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_dec_legal;

    always_comb begin
        w_dec_op      = OP_ADD;
        w_dec_imm     = 32'h0;
        w_dec_use_imm = 1'b0;
        w_dec_wr      = 1'b0;
        w_dec_ok      = 1'b0;
        w_use_rd      = 1'b0;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        case (w_opc)
            7'b0010011: begin
                w_dec_imm     = {{20{r_ir[31]}}, r_ir[31:20]};
                w_dec_use_imm = 1'b1;
                w_dec_wr      = 1'b1;
                w_use_rd      = 1'b1;
                w_use_rs1     = 1'b1;
                w_dec_ok      = 1'b1;
                case (w_f3)
                    3'b000:  w_dec_op = OP_ADD;
                    3'b010:  w_dec_op = OP_SLT;
                    3'b100:  w_dec_op = OP_XOR;
                    3'b110:  w_dec_op = OP_OR;
                    3'b111:  w_dec_op = OP_AND;
                    default: w_dec_ok = 1'b0;
                endcase
            end
            7'b0110011: begin
                w_dec_wr  = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_dec_ok = 1'b1;
                    case (w_f3)
                        3'b000:  w_dec_op = OP_ADD;
                        3'b010:  w_dec_op = OP_SLT;
                        3'b100:  w_dec_op = OP_XOR;
                        3'b110:  w_dec_op = OP_OR;
                        3'b111:  w_dec_op = OP_AND;
                        default: w_dec_ok = 1'b0;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_dec_op = OP_SUB;
                    w_dec_ok = 1'b1;
                end
            end
            7'b0110111: begin
                w_dec_op  = OP_LUI;
                w_dec_imm = {r_ir[31:12], 12'h0};
                w_dec_wr  = 1'b1;
                w_use_rd  = 1'b1;
                w_dec_ok  = 1'b1;
            end
            7'b1101111: begin
                w_dec_op  = OP_JAL;
                w_dec_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
                w_dec_wr  = 1'b1;
                w_use_rd  = 1'b1;
                w_dec_ok  = 1'b1;
            end
            7'b1100011: begin
                w_dec_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (w_f3 == 3'b000) begin
                    w_dec_op = OP_BEQ;
                    w_dec_ok = 1'b1;
                end else if (w_f3 == 3'b001) begin
                    w_dec_op = OP_BNE;
                    w_dec_ok = 1'b1;
                end
            end
            default: w_dec_ok = 1'b0;
        endcase
    end

    // Register indices beyond REG_CNT are only illegal on fields the format actually uses.
    assign w_dec_legal = w_dec_ok
                       && !(w_use_rd  && idx_bad(w_rd))
                       && !(w_use_rs1 && idx_bad(w_rs1))
                       && !(w_use_rs2 && idx_bad(w_rs2));

    logic [31:0] w_opb;
    logic [31:0] w_alu;
    logic        w_take;

    assign w_opb = r_use_imm ? r_imm : r_b;

    always_comb begin
        w_alu  = 32'h0;
        w_take = 1'b0;
        case (r_op)
            OP_ADD:  w_alu = r_a + w_opb;
            OP_SUB:  w_alu = r_a - w_opb;
            OP_SLT:  w_alu = {31'b0, $signed(r_a) < $signed(w_opb)};
            OP_XOR:  w_alu = r_a ^ w_opb;
            OP_OR:   w_alu = r_a | w_opb;
            OP_AND:  w_alu = r_a & w_opb;
            OP_LUI:  w_alu = r_imm;
            OP_JAL: begin
                w_alu  = r_pc + 32'd4;
                w_take = 1'b1;
            end
            OP_BEQ:  w_take = (r_a == r_b);
            OP_BNE:  w_take = (r_a != r_b);
            default: w_alu = 32'h0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  if (w_ivalid) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_dec_legal ? S_EXEC : S_HALT;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_FETCH;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_imm     <= 32'h0;
            r_res     <= 32'h0;
            r_tgt     <= 32'h0;
            r_op      <= OP_ADD;
            r_use_imm <= 1'b0;
            r_wr      <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
        end else begin
            case (r_state)
                S_FETCH: if (w_ivalid) r_ir <= w_idata;
                S_DECODE: begin
                    r_a       <= r_rf[w_rs1];
                    r_b       <= r_rf[w_rs2];
                    r_imm     <= w_dec_imm;
                    r_op      <= w_dec_op;
                    r_use_imm <= w_dec_use_imm;
                    r_wr      <= w_dec_wr;
                end
                S_EXEC: begin
                    r_res <= w_alu;
                    r_tgt <= w_take ? (r_pc + r_imm) : (r_pc + 32'd4);
                end
                S_WB: begin
                    // x0 is never written, so it reads back as zero without a read-side mux.
                    if (w_rf_we) r_rf[w_rd] <= r_res;
                    r_pc <= r_tgt;
                end
                default: ;
            endcase
        end
    end

    assign w_ireq   = (r_state == S_FETCH) && w_rst_n;
    assign w_iaddr  = r_pc;
    assign w_pc     = r_pc;
    assign w_retire = (r_state == S_WB);
    assign w_rf_we  = w_retire && r_wr && (w_rd != 5'd0);
    assign w_rf_wa  = w_rf_we ? w_rd : 5'd0;
    assign w_rf_wd  = w_rf_we ? r_res : 32'h0;
    assign w_halt   = (r_state == S_HALT);

endmodule
